// File: rtl/tick_rate_decoder.sv
// tick_rate_decoder
// Measures the half-period of a divided square wave (slow_clk) in CLK_50
// cycles and decodes it back to the 0..5 frequency index. The index is
// reported together with a lock flag and the last measured half-period.
// Optional build macro: CHANGE_PULSE_EN adds the freq_chg output, a
// one-cycle pulse whenever a new lock lands on a different index.

module tick_rate_decoder #(
    parameter int unsigned N0        = 25000000,
    parameter int unsigned N1        = 12500000,
    parameter int unsigned N2        = 8333333,
    parameter int unsigned N3        = 6250000,
    parameter int unsigned N4        = 5000000,
    parameter int unsigned N5        = 4166667,
    parameter int unsigned TOL_SHIFT = 6,
    parameter int unsigned LOCK_CNT  = 2,
    parameter int unsigned TIMEOUT   = 50000000,
    parameter int unsigned CW        = 26
) (
    input  logic          CLK_50,
    input  logic          reset,
    input  logic          slow_clk,
    output logic [2:0]    freq_num,
    output logic          locked,
    output logic [CW-1:0] period
`ifdef CHANGE_PULSE_EN
    ,
    output logic          freq_chg
`endif
);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_MEASURE,
        S_LOCKED
    } state_e;

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [3:0]    LOCK_C    = 4'(LOCK_CNT);
    localparam logic [CW-1:0] NOMINAL [6] = '{CW'(N0), CW'(N1), CW'(N2),
                                              CW'(N3), CW'(N4), CW'(N5)};

    state_e        state;
    state_e        state_next;

    logic          sync_meta;
    logic          sync_stable;
    logic          sync_prev;
    logic          edge_seen;

    logic [CW-1:0] count;

    logic          match_hit;
    logic [2:0]    match_idx;
    logic [CW-1:0] diff;

    logic [3:0]    streak;
    logic [3:0]    streak_next;
    logic [2:0]    cand;
    logic [2:0]    cand_next;
    logic [2:0]    freq_q;
    logic [2:0]    freq_next;
    logic [CW-1:0] period_q;
    logic [CW-1:0] period_next;
`ifdef CHANGE_PULSE_EN
    logic          chg_q;
    logic          chg_next;
`endif

    // Two-flop synchroniser, then a history flop whose XOR flags either slow_clk edge one cycle later
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            sync_prev   <= 1'b0;
            edge_seen   <= 1'b0;
        end else begin
            sync_meta   <= slow_clk;
            sync_stable <= sync_meta;
            sync_prev   <= sync_stable;
            edge_seen   <= sync_stable ^ sync_prev;
        end
    end

    // Cycles since the last detected edge; restarts at 1 so its value at an edge is the full half-period
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (edge_seen) begin
            count <= {{(CW-1){1'b0}}, 1'b1};
        end else if (count < TIMEOUT_C) begin
            count <= count + 1'b1;
        end
    end

    // Find the lowest index whose tolerance window contains the current count
    always_comb begin
        match_hit = 1'b0;
        match_idx = 3'd0;
        diff      = '0;
        for (int k = 5; k >= 0; k--) begin
            diff = (count >= NOMINAL[k]) ? (count - NOMINAL[k]) : (NOMINAL[k] - count);
            if (diff <= (NOMINAL[k] >> TOL_SHIFT)) begin
                match_hit = 1'b1;
                match_idx = 3'(k);
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            state <= S_SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath decisions; an edge always takes priority over the timeout
    always_comb begin
        state_next  = state;
        streak_next = streak;
        cand_next   = cand;
        freq_next   = freq_q;
        period_next = period_q;
`ifdef CHANGE_PULSE_EN
        chg_next    = 1'b0;
`endif
        if (edge_seen) begin
            unique case (state)
                S_SEARCH: begin
                    state_next  = S_MEASURE;
                    streak_next = '0;
                end
                S_MEASURE: begin
                    period_next = count;
                    if (!match_hit) begin
                        streak_next = '0;
                    end else if (match_idx == cand) begin
                        streak_next = streak + 4'd1;
                    end else begin
                        cand_next   = match_idx;
                        streak_next = 4'd1;
                    end
                    if (match_hit && (streak_next == LOCK_C)) begin
                        freq_next  = cand_next;
                        state_next = S_LOCKED;
`ifdef CHANGE_PULSE_EN
                        chg_next   = (cand_next != freq_q);
`endif
                    end
                end
                S_LOCKED: begin
                    period_next = count;
                    if (!match_hit) begin
                        state_next  = S_MEASURE;
                        streak_next = '0;
                    end else if (match_idx != freq_q) begin
                        state_next  = S_MEASURE;
                        cand_next   = match_idx;
                        streak_next = 4'd1;
                    end
                end
                default: begin
                    state_next  = S_SEARCH;
                    streak_next = '0;
                end
            endcase
        end else if ((state != S_SEARCH) && (count == TIMEOUT_C)) begin
            state_next  = S_SEARCH;
            streak_next = '0;
        end
    end

    // Registers holding the streak, candidate and reported values
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            streak   <= '0;
            cand     <= 3'd0;
            freq_q   <= 3'd0;
            period_q <= '0;
`ifdef CHANGE_PULSE_EN
            chg_q    <= 1'b0;
`endif
        end else begin
            streak   <= streak_next;
            cand     <= cand_next;
            freq_q   <= freq_next;
            period_q <= period_next;
`ifdef CHANGE_PULSE_EN
            chg_q    <= chg_next;
`endif
        end
    end

    // Outputs come straight from registers; lock is simply being in the LOCKED state
    always_comb begin
        locked   = (state == S_LOCKED);
        freq_num = freq_q;
        period   = period_q;
`ifdef CHANGE_PULSE_EN
        freq_chg = chg_q;
`endif
    end

endmodule

// File: tb/tb_tick_rate_decoder.sv
// tb_tick_rate_decoder
// Self-checking bench for tick_rate_decoder using small test parameters.
// A reference model tracks the times of slow_clk edges and decodes each
// half-period arithmetically; outputs are compared every cycle plus at
// directed checkpoints. Build with CHANGE_PULSE_EN to also check freq_chg.

`timescale 1ns/1ps

module tb_tick_rate_decoder;

    localparam int CW        = 11;
    localparam int TIMEOUT   = 1000;
    localparam int LOCK_CNT  = 2;
    localparam int TOL_SHIFT = 4;
    localparam int NOM [6]   = '{600, 500, 400, 300, 200, 100};

    logic          CLK_50   = 1'b0;
    logic          reset    = 1'b0;
    logic          slow_clk = 1'b0;
    logic [2:0]    freq_num;
    logic          locked;
    logic [CW-1:0] period;
`ifdef CHANGE_PULSE_EN
    logic          freq_chg;
`endif

    int errorCount = 0;
    int checkCount = 0;
    int cyc        = 0;
    int detQ [$];

    // Reference model: 0 = search, 1 = measuring, 2 = locked
    int mMode   = 0;
    int mCand   = 0;
    int mStreak = 0;
    int mFreq   = 0;
    int mPeriod = 0;
    int mChg    = 0;
    int mLast   = 0;

    tick_rate_decoder #(
        .N0(600), .N1(500), .N2(400), .N3(300), .N4(200), .N5(100),
        .TOL_SHIFT(TOL_SHIFT), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .CLK_50   (CLK_50),
        .reset    (reset),
        .slow_clk (slow_clk),
        .freq_num (freq_num),
        .locked   (locked),
        .period   (period)
`ifdef CHANGE_PULSE_EN
        ,
        .freq_chg (freq_chg)
`endif
    );

    always #5 CLK_50 = ~CLK_50;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Lowest index whose nominal half-period is within its tolerance of m, or -1
    function automatic int matchIndex(input int m);
        for (int k = 0; k < 6; k++) begin
            int d;
            d = (m > NOM[k]) ? (m - NOM[k]) : (NOM[k] - m);
            if (d <= NOM[k] / (1 << TOL_SHIFT)) return k;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mMode = 0; mCand = 0; mStreak = 0; mFreq = 0; mPeriod = 0; mChg = 0;
        mLast = cyc;
        detQ.delete();
    endtask

    // One detected edge at cycle e: measured value is the gap to the previous edge
    task automatic modelEdge(input int e);
        int m;
        int k;
        m = e - mLast;
        if (m > TIMEOUT) m = TIMEOUT;
        mLast = e;
        if (mMode == 0) begin
            mMode = 1;
            mStreak = 0;
        end else begin
            mPeriod = m;
            k = matchIndex(m);
            if (mMode == 1) begin
                if (k < 0) mStreak = 0;
                else if (k == mCand) mStreak++;
                else begin mCand = k; mStreak = 1; end
                if (k >= 0 && mStreak == LOCK_CNT) begin
                    mChg  = (mCand != mFreq) ? 1 : 0;
                    mFreq = mCand;
                    mMode = 2;
                end
            end else begin
                if (k < 0) begin
                    mMode = 1; mStreak = 0;
                end else if (k != mFreq) begin
                    mMode = 1; mCand = k; mStreak = 1;
                end
            end
        end
    endtask

    always @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            modelReset();
        end else begin
            cyc++;
            mChg = 0;
            if (detQ.size() > 0 && detQ[0] == cyc - 1) begin
                void'(detQ.pop_front());
                modelEdge(cyc - 1);
            end else if (mMode != 0 && (cyc - 1 - mLast) >= TIMEOUT) begin
                mMode = 0;
                mStreak = 0;
            end
        end
    end

    always @(negedge CLK_50) begin
        logic [2:0]    expFreq;
        logic [CW-1:0] expPeriod;
        logic          expLocked;
        expFreq   = 3'(mFreq);
        expPeriod = CW'(mPeriod);
        expLocked = (mMode == 2);
        checkOutput("outputs", int'({locked, freq_num, period}),
                    int'({expLocked, expFreq, expPeriod}));
`ifdef CHANGE_PULSE_EN
        checkOutput("freq_chg", int'(freq_chg), mChg);
`endif
    end

    task automatic toggleSlow();
        slow_clk = ~slow_clk;
        detQ.push_back(cyc + 3);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge CLK_50);
            #1;
        end
    endtask

    task automatic applyStimulus(input int halfp, input int n);
        repeat (n) begin
            toggleSlow();
            waitCycles(halfp);
        end
    endtask

    task automatic checkState(input string tag, input int expLocked, input int expFreq, input int expPeriod);
        checkOutput({tag, "_locked"}, int'(locked), expLocked);
        checkOutput({tag, "_freq"},   int'(freq_num), expFreq);
        checkOutput({tag, "_period"}, int'(period), expPeriod);
    endtask

    initial begin
        reset    = 1'b0;
        slow_clk = 1'b0;
        #2;
        checkState("reset", 0, 0, 0);
        repeat (3) @(posedge CLK_50);
        #1;
        reset = 1'b1;
        waitCycles(5);

        // Nominal 300: lock lands 4 cycles after the third transition
        applyStimulus(300, 2);
        toggleSlow();
        waitCycles(3);
        checkOutput("t300_prelock", int'(locked), 0);
        waitCycles(1);
        checkState("t300_lock", 1, 3, 300);
        waitCycles(296);
        applyStimulus(300, 2);

        // 320 is outside every window: lock drops and never returns
        applyStimulus(320, 6);
        checkState("t320", 0, 3, 320);

        // 306 is inside the index-3 window
        applyStimulus(306, 4);
        checkState("t306", 1, 3, 306);

        // Switch to 100: drop on the first 100-cycle edge, relock to 5 on the next
        toggleSlow();
        waitCycles(100);
        toggleSlow();
        waitCycles(4);
        checkState("t100_drop", 0, 3, 100);
        waitCycles(96);
        toggleSlow();
        waitCycles(4);
        checkState("t100_relock", 1, 5, 100);
`ifdef CHANGE_PULSE_EN
        checkOutput("t100_chg_on", int'(freq_chg), 1);
        waitCycles(1);
        checkOutput("t100_chg_off", int'(freq_chg), 0);
        waitCycles(95);
`else
        waitCycles(96);
`endif

        // Lock at 0 then stop toggling: timeout drops lock, index and period hold
        applyStimulus(600, 3);
        checkState("t600_lock", 1, 0, 600);
        waitCycles(403);
        checkOutput("t600_pre_timeout", int'(locked), 1);
        waitCycles(1);
        checkState("t600_timeout", 0, 0, 600);
        waitCycles(20);

        // Lock at 4, then reset mid-measurement
        applyStimulus(200, 4);
        checkState("t200_lock", 1, 4, 200);
        toggleSlow();
        waitCycles(50);
        reset    = 1'b0;
        slow_clk = 1'b0;
        #1;
        checkState("t200_reset", 0, 0, 0);
        @(posedge CLK_50);
        #1;
        waitCycles(2);
        reset = 1'b1;
        waitCycles(5);
        applyStimulus(200, 2);
        toggleSlow();
        waitCycles(3);
        checkOutput("t200_post_prelock", int'(locked), 0);
        waitCycles(1);
        checkState("t200_post_lock", 1, 4, 200);
        waitCycles(196);

        // Randomized segments: in-window, out-of-window, arbitrary and stalled slow_clk
        for (int seg = 0; seg < 24; seg++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                waitCycles(int'($urandom_range(900, 1200)));
            end else if (kind == 1) begin
                repeat (3) begin
                    toggleSlow();
                    waitCycles(int'($urandom_range(50, 1000)));
                end
            end else begin
                int k;
                int tol;
                int n;
                k   = int'($urandom_range(0, 5));
                tol = NOM[k] / (1 << TOL_SHIFT);
                n   = int'($urandom_range(2, 5));
                repeat (n) begin
                    int hp;
                    hp = NOM[k] - tol - 4 + int'($urandom_range(0, 2 * tol + 8));
                    toggleSlow();
                    waitCycles(hp);
                end
            end
        end

        // Edge arriving exactly as the counter saturates is measured, not timed out
        applyStimulus(1000, 3);
        waitCycles(10);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
